// File: rtl/cmos_capture_rgb565.sv
// Byte-to-pixel capture for an 8-bit RGB565 CMOS sensor port: settle-frame skipping,
// frame-aligned capture start, pixel coordinates and malformed line/frame flags.
module cmos_capture_rgb565 #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int FRAME_SKIP = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_db,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);
    localparam int SKW = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP) : 1;
    localparam logic [SKW-1:0] SKIP_LAST = (FRAME_SKIP > 0) ? SKW'(FRAME_SKIP - 1) : '0;
    localparam logic [10:0] H_L = 11'(H_ACTIVE);
    localparam logic [10:0] V_L = 11'(V_ACTIVE);

    typedef enum logic [1:0] {ST_SKIP = 2'd0, ST_WAIT_FB = 2'd1, ST_CAPTURE = 2'd2} state_t;
    localparam state_t ST_RESET = (FRAME_SKIP == 0) ? ST_WAIT_FB : ST_SKIP;

    state_t         state_q, state_d;
    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
    logic           vsync_q, vsync_prev_q, href_q, href_prev_q;
    logic [7:0]     db_q;
    logic           phase_q, phase_d, abort_q, abort_d;
    logic [7:0]     hi_q, hi_d;
    logic [10:0]    px_cnt_q, px_cnt_d, line_cnt_q, line_cnt_d;
    logic           px_ovf_q, px_ovf_d, line_ovf_q, line_ovf_d;
    logic           asm_valid_q, asm_valid_d;
    logic [15:0]    asm_data_q, asm_data_d;
    logic [10:0]    asm_x_q, asm_x_d, asm_y_q, asm_y_d;
    logic           frame_start_s1_q, frame_start_s1_d, frame_done_s1_q, frame_done_s1_d;
    logic           frame_err_s1_q, frame_err_s1_d, line_err_s1_q, line_err_s1_d;
    logic           pix_valid_q, frame_start_q, frame_done_q, frame_err_q, line_err_q;
    logic [15:0]    pix_data_q, pix_data_d;
    logic [10:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic           fb, le, capturing;

    assign fb        = vsync_q & ~vsync_prev_q;
    assign le        = href_prev_q & ~href_q;
    assign capturing = (state_q == ST_CAPTURE);

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        case (state_q)
            ST_SKIP: if (fb) begin
                if (skip_cnt_q == SKIP_LAST) state_d = ST_WAIT_FB;
                else                          skip_cnt_d = skip_cnt_q + SKW'(1);
            end
            ST_WAIT_FB: if (fb) state_d = ST_CAPTURE;
            default: state_d = ST_CAPTURE;
        endcase
    end

    always_comb begin
        frame_start_s1_d = fb & (state_q == ST_WAIT_FB || state_q == ST_CAPTURE);
        frame_done_s1_d  = fb & capturing;
        frame_err_s1_d   = fb & capturing & (line_ovf_q | (line_cnt_q != V_L));
    end

    // Frame boundary wins over everything on the line; a line cut by it is ignored until href drops.
    always_comb begin
        phase_d       = phase_q;
        hi_d          = hi_q;
        px_cnt_d      = px_cnt_q;
        px_ovf_d      = px_ovf_q;
        line_cnt_d    = line_cnt_q;
        line_ovf_d    = line_ovf_q;
        abort_d       = abort_q;
        asm_valid_d   = 1'b0;
        asm_data_d    = asm_data_q;
        asm_x_d       = asm_x_q;
        asm_y_d       = asm_y_q;
        line_err_s1_d = 1'b0;
        if (fb) begin
            phase_d    = 1'b0;
            px_cnt_d   = '0;
            px_ovf_d   = 1'b0;
            line_cnt_d = '0;
            line_ovf_d = 1'b0;
            abort_d    = href_q;
        end else if (!href_q) begin
            phase_d = 1'b0;
            if (le) begin
                if (capturing && !abort_q) begin
                    line_err_s1_d = phase_q | px_ovf_q | (px_cnt_q != H_L);
                    if (line_cnt_q == V_L) line_ovf_d = 1'b1;
                    else                   line_cnt_d = line_cnt_q + 11'd1;
                end
                px_cnt_d = '0;
                px_ovf_d = 1'b0;
                abort_d  = 1'b0;
            end
        end else if (!phase_q) begin
            phase_d = 1'b1;
            hi_d    = db_q;
        end else begin
            phase_d = 1'b0;
            if (!abort_q) begin
                asm_valid_d = capturing && (px_cnt_q < H_L) && (line_cnt_q < V_L);
                asm_data_d  = {hi_q, db_q};
                asm_x_d     = px_cnt_q;
                asm_y_d     = line_cnt_q;
                if (px_cnt_q == H_L) px_ovf_d = 1'b1;
                else                 px_cnt_d = px_cnt_q + 11'd1;
            end
        end
    end

    always_comb begin
        pix_data_d = asm_valid_q ? asm_data_q : pix_data_q;
        pix_x_d    = asm_valid_q ? asm_x_q    : pix_x_q;
        pix_y_d    = asm_valid_q ? asm_y_q    : pix_y_q;
    end

    // Vsync copies reset high so releasing reset during blanking cannot fake a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;      skip_cnt_q <= '0;
            vsync_q <= 1'b1;          vsync_prev_q <= 1'b1;
            href_q <= 1'b0;           href_prev_q <= 1'b0;     db_q <= '0;
            phase_q <= 1'b0;          abort_q <= 1'b0;         hi_q <= '0;
            px_cnt_q <= '0;           px_ovf_q <= 1'b0;
            line_cnt_q <= '0;         line_ovf_q <= 1'b0;
            asm_valid_q <= 1'b0;      asm_data_q <= '0;        asm_x_q <= '0;   asm_y_q <= '0;
            frame_start_s1_q <= 1'b0; frame_done_s1_q <= 1'b0;
            frame_err_s1_q <= 1'b0;   line_err_s1_q <= 1'b0;
            pix_valid_q <= 1'b0;      pix_data_q <= '0;        pix_x_q <= '0;   pix_y_q <= '0;
            frame_start_q <= 1'b0;    frame_done_q <= 1'b0;
            frame_err_q <= 1'b0;      line_err_q <= 1'b0;
        end else begin
            state_q <= state_d;       skip_cnt_q <= skip_cnt_d;
            vsync_q <= cmos_vsync;    vsync_prev_q <= vsync_q;
            href_q <= cmos_href;      href_prev_q <= href_q;   db_q <= cmos_db;
            phase_q <= phase_d;       abort_q <= abort_d;      hi_q <= hi_d;
            px_cnt_q <= px_cnt_d;     px_ovf_q <= px_ovf_d;
            line_cnt_q <= line_cnt_d; line_ovf_q <= line_ovf_d;
            asm_valid_q <= asm_valid_d; asm_data_q <= asm_data_d;
            asm_x_q <= asm_x_d;       asm_y_q <= asm_y_d;
            frame_start_s1_q <= frame_start_s1_d; frame_done_s1_q <= frame_done_s1_d;
            frame_err_s1_q <= frame_err_s1_d;     line_err_s1_q <= line_err_s1_d;
            pix_valid_q <= asm_valid_q; pix_data_q <= pix_data_d;
            pix_x_q <= pix_x_d;       pix_y_q <= pix_y_d;
            frame_start_q <= frame_start_s1_q; frame_done_q <= frame_done_s1_q;
            frame_err_q <= frame_err_s1_q;     line_err_q <= line_err_s1_q;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Randomized stream bench for cmos_capture_rgb565 (H=4, V=2, FRAME_SKIP=2) checked
// against a line/frame-level reference model with cycle-exact output timing.
module tb_cmos_capture_rgb565;
    localparam int H = 4, V = 2, FS = 2, LAT = 3;
    localparam logic [1:0] K_LINE = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2, K_START = 2'd3;

    logic        clk = 1'b0, rst_n = 1'b0, cmos_vsync = 1'b0, cmos_href = 1'b0;
    logic [7:0]  cmos_db = '0;
    logic [15:0] pix_data;
    logic        pix_valid, frame_start, frame_done, line_err, frame_err;
    logic [10:0] pix_x, pix_y;

    cmos_capture_rgb565 #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_SKIP(FS)) dut (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
        .cmos_db(cmos_db), .pix_data(pix_data), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .frame_start(frame_start), .frame_done(frame_done),
        .line_err(line_err), .frame_err(frame_err));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    // pixel word {cycle, data, x, y}; event word {cycle, kind}
    logic [61:0] obs_pix[$], exp_pix[$];
    logic [25:0] obs_ev[$], exp_ev[$];

    always @(negedge clk) if (rst_n) begin
        if (pix_valid)   obs_pix.push_back({cyc[23:0], pix_data, pix_x, pix_y});
        if (line_err)    obs_ev.push_back({cyc[23:0], K_LINE});
        if (frame_done)  obs_ev.push_back({cyc[23:0], K_DONE});
        if (frame_err)   obs_ev.push_back({cyc[23:0], K_ERR});
        if (frame_start) obs_ev.push_back({cyc[23:0], K_START});
    end

    // Reference model: frames seen since reset, whether this frame is captured, lines ended.
    int          m_fbs, m_line;
    bit          m_cap, m_seq_mode;
    logic [15:0] m_last;
    logic [7:0]  m_seq;

    task automatic model_reset();
        m_fbs = 0; m_line = 0; m_cap = 1'b0; m_last = '0;
        obs_pix.delete(); exp_pix.delete(); obs_ev.delete(); exp_ev.delete();
    endtask

    task automatic clear_logs();
        obs_pix.delete(); exp_pix.delete(); obs_ev.delete(); exp_ev.delete();
    endtask

    function automatic logic [7:0] next_byte();
        logic [7:0] b;
        if (m_seq_mode) begin b = m_seq; m_seq = m_seq + 8'h22; end
        else b = 8'($urandom);
        return b;
    endfunction

    task automatic drive(input logic vs, input logic hr, input logic [7:0] db, output int k);
        @(negedge clk);
        cmos_vsync = vs; cmos_href = hr; cmos_db = db;
        k = cyc;
    endtask

    task automatic model_fb(input int k);
        logic [23:0] t;
        t = 24'(k + LAT);
        if (m_cap) begin
            exp_ev.push_back({t, K_DONE});
            if (m_line != V) exp_ev.push_back({t, K_ERR});
        end
        m_fbs++;
        if (m_fbs >= FS + 1) begin m_cap = 1'b1; exp_ev.push_back({t, K_START}); end
        m_line = 0;
    endtask

    task automatic send_fb();
        int k;
        repeat (2) drive(1'b0, 1'b0, 8'h00, k);
        drive(1'b1, 1'b0, 8'h00, k);
        model_fb(k);
        repeat (3) drive(1'b1, 1'b0, 8'h00, k);
        repeat (2) drive(1'b0, 1'b0, 8'h00, k);
    endtask

    task automatic send_bytes(input int n, output logic [7:0] hi);
        int k;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = next_byte();
            drive(1'b0, 1'b1, b, k);
            if (i % 2 == 0) hi = b;
            else if (m_cap && (i / 2) < H && m_line < V) begin
                exp_pix.push_back({24'(k + LAT), hi, b, 11'(i / 2), 11'(m_line)});
                m_last = {hi, b};
            end
        end
    endtask

    task automatic send_line(input int n);
        int k;
        logic [7:0] hi;
        send_bytes(n, hi);
        drive(1'b0, 1'b0, 8'h00, k);
        if (m_cap) begin
            if ((n % 2) != 0 || (n / 2) != H) exp_ev.push_back({24'(k + LAT), K_LINE});
            m_line++;
        end
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 8'h00, k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({pix_data, pix_valid, pix_x, pix_y, frame_start, frame_done, line_err, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got data=%h valid=%b x=%0d y=%0d fs=%b fd=%b le=%b fe=%b, expected all 0",
                     pix_data, pix_valid, pix_x, pix_y, frame_start, frame_done, line_err, frame_err);
        end
        rst_n = 1'b1;
        model_reset();
        $display("[TB] reset checked");
    endtask

    task automatic test_skip_and_capture();
        clear_logs();
        m_seq_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_fb();
            m_seq = 8'h12;
            repeat (V) send_line(2 * H);
        end
        send_fb();
        m_seq_mode = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++;
        if (obs_pix.size() != exp_pix.size() || obs_ev.size() != exp_ev.size()) begin
            n_fail++;
            $display("FAIL skip_capture counts: got %0d pix %0d ev, expected %0d pix %0d ev",
                     obs_pix.size(), obs_ev.size(), exp_pix.size(), exp_ev.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            n_tests++;
            if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL skip_capture pixel %0d: got %h expected %h", i, obs_pix[i], exp_pix[i]); end
        end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_tests++;
            if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL skip_capture event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        $display("[TB] skip_and_capture: %0d pixels, %0d events", exp_pix.size(), exp_ev.size());
    endtask

    task automatic test_line_errors();
        clear_logs();
        send_line(9);
        send_line(2 * H);
        send_fb();
        send_line(12);
        send_line(2 * H);
        send_fb();
        repeat (6) @(negedge clk);
        n_tests++;
        if (obs_pix.size() != exp_pix.size() || obs_ev.size() != exp_ev.size()) begin
            n_fail++;
            $display("FAIL line_errors counts: got %0d pix %0d ev, expected %0d pix %0d ev",
                     obs_pix.size(), obs_ev.size(), exp_pix.size(), exp_ev.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            n_tests++;
            if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL line_errors pixel %0d: got %h expected %h", i, obs_pix[i], exp_pix[i]); end
        end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_tests++;
            if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL line_errors event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        $display("[TB] line_errors: %0d pixels, %0d events", exp_pix.size(), exp_ev.size());
    endtask

    task automatic test_short_frame();
        clear_logs();
        send_line(2 * H);
        send_fb();
        repeat (6) @(negedge clk);
        n_tests++;
        if (obs_pix.size() != exp_pix.size() || obs_ev.size() != exp_ev.size()) begin
            n_fail++;
            $display("FAIL short_frame counts: got %0d pix %0d ev, expected %0d pix %0d ev",
                     obs_pix.size(), obs_ev.size(), exp_pix.size(), exp_ev.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            n_tests++;
            if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL short_frame pixel %0d: got %h expected %h", i, obs_pix[i], exp_pix[i]); end
        end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_tests++;
            if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL short_frame event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        $display("[TB] short_frame: %0d pixels, %0d events", exp_pix.size(), exp_ev.size());
    endtask

    task automatic test_fb_mid_line();
        int k;
        logic [7:0] hi;
        clear_logs();
        send_line(2 * H);
        send_bytes(4, hi);
        drive(1'b1, 1'b1, next_byte(), k);
        model_fb(k);
        repeat (3) drive(1'b1, 1'b1, next_byte(), k);
        repeat (2) drive(1'b1, 1'b0, 8'h00, k);
        repeat (2) drive(1'b0, 1'b0, 8'h00, k);
        repeat (V) send_line(2 * H);
        send_fb();
        repeat (6) @(negedge clk);
        n_tests++;
        if (obs_pix.size() != exp_pix.size() || obs_ev.size() != exp_ev.size()) begin
            n_fail++;
            $display("FAIL fb_mid_line counts: got %0d pix %0d ev, expected %0d pix %0d ev",
                     obs_pix.size(), obs_ev.size(), exp_pix.size(), exp_ev.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            n_tests++;
            if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL fb_mid_line pixel %0d: got %h expected %h", i, obs_pix[i], exp_pix[i]); end
        end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_tests++;
            if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL fb_mid_line event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        $display("[TB] fb_mid_line: %0d pixels, %0d events", exp_pix.size(), exp_ev.size());
    endtask

    task automatic test_back_to_back();
        int lens[8] = '{8, 8, 8, 8, 7, 9, 10, 6};
        clear_logs();
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) send_line(lens[$urandom_range(0, 7)]);
            send_fb();
        end
        repeat (6) @(negedge clk);
        n_tests++;
        if (obs_pix.size() != exp_pix.size() || obs_ev.size() != exp_ev.size()) begin
            n_fail++;
            $display("FAIL back_to_back counts: got %0d pix %0d ev, expected %0d pix %0d ev",
                     obs_pix.size(), obs_ev.size(), exp_pix.size(), exp_ev.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            n_tests++;
            if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL back_to_back pixel %0d: got %h expected %h", i, obs_pix[i], exp_pix[i]); end
        end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_tests++;
            if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL back_to_back event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        $display("[TB] back_to_back: %0d pixels, %0d events", exp_pix.size(), exp_ev.size());
    endtask

    task automatic test_hold();
        repeat (5) @(negedge clk);
        n_tests++;
        if (pix_valid !== 1'b0 || pix_data !== m_last) begin
            n_fail++;
            $display("FAIL hold: got valid=%b data=%h, expected valid=0 data=%h", pix_valid, pix_data, m_last);
        end
        $display("[TB] hold: pix_data %h", pix_data);
    endtask

    task automatic test_reset_mid_line();
        logic [7:0] hi;
        clear_logs();
        send_bytes(5, hi);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({pix_data, pix_valid, pix_x, pix_y, frame_start, frame_done, line_err, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got data=%h valid=%b x=%0d y=%0d fs=%b fd=%b le=%b fe=%b, expected all 0",
                     pix_data, pix_valid, pix_x, pix_y, frame_start, frame_done, line_err, frame_err);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_line(5);
        for (int f = 0; f < FS + 1; f++) begin
            send_fb();
            repeat (V) send_line(2 * H);
        end
        send_fb();
        repeat (6) @(negedge clk);
        n_tests++;
        if (obs_pix.size() != exp_pix.size() || obs_ev.size() != exp_ev.size()) begin
            n_fail++;
            $display("FAIL reset_mid counts: got %0d pix %0d ev, expected %0d pix %0d ev",
                     obs_pix.size(), obs_ev.size(), exp_pix.size(), exp_ev.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            n_tests++;
            if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL reset_mid pixel %0d: got %h expected %h", i, obs_pix[i], exp_pix[i]); end
        end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_tests++;
            if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL reset_mid event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        $display("[TB] reset_mid_line: %0d pixels, %0d events", exp_pix.size(), exp_ev.size());
    endtask

    initial begin
        m_seq_mode = 1'b0;
        m_seq = 8'h12;
        model_reset();
        test_reset();
        test_skip_and_capture();
        test_line_errors();
        test_short_frame();
        test_fb_mid_line();
        test_back_to_back();
        test_hold();
        test_reset_mid_line();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cmos_capture_rgb565.md
CMOS_CAPTURE_RGB565 -- requirements
Module: cmos_capture_rgb565

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameter FRAME_SKIP, default 10, frames discarded after reset for sensor settling (0 = none).
REQ-004 SHALL have ports, in this order:
 clk  in  1  pixel clock (board connects cmos_pclk)
 rst_n  in  1  reset, asynchronous, active-low
 cmos_vsync  in  1  frame sync, high during vertical blanking
 cmos_href  in  1  line valid, high while bytes valid
 cmos_db  in  8  sensor byte stream, RGB565 high byte first
 pix_data  out  16  assembled RGB565 pixel {R5,G6,B5}
 pix_valid  out  1  one-cycle qualifier for pix_data
 pix_x  out  11  column of current pix_data
 pix_y  out  11  line of current pix_data
 frame_start  out  1  one-cycle pulse, capture of a frame begins
 frame_done  out  1  one-cycle pulse, captured frame ended
 line_err  out  1  one-cycle pulse, malformed line
 frame_err  out  1  one-cycle pulse, captured frame had line count != V_ACTIVE

Function
REQ-005 SHALL register cmos_vsync, cmos_href, cmos_db once on entry; all edge detection uses registered copies.
REQ-006 SHALL treat a registered-vsync rising edge as frame boundary (FB) and a registered-href falling edge as line end (LE).
REQ-007 SHALL implement states SKIP, WAIT_FB, CAPTURE.
REQ-008 SKIP: counts FBs; on FB when count = FRAME_SKIP-1 -> WAIT_FB; FRAME_SKIP = 0 -> reset exits directly to WAIT_FB.
REQ-009 WAIT_FB: on FB -> CAPTURE, pulse frame_start; never start capture mid-frame.
REQ-010 CAPTURE: on FB -> pulse frame_done, and frame_err if lines completed != V_ACTIVE; pulse frame_start same cycle, remain CAPTURE.
REQ-011 Byte phase SHALL clear when href is low; first href-high byte latched as high byte, second completes pixel {hi,lo}.
REQ-012 pix_valid SHALL assert 2 clk after the clk edge that samples the second byte of a pair, only in CAPTURE, only while pix_x < H_ACTIVE and pix_y < V_ACTIVE.
REQ-013 pix_x SHALL be 0 for first pixel of each line, +1 per completed pixel; pixels with index >= H_ACTIVE discarded, counter saturates at H_ACTIVE.
REQ-014 pix_y SHALL be 0 for first line after FB, +1 at each LE in CAPTURE, saturating at V_ACTIVE; lines >= V_ACTIVE discarded.
REQ-015 At LE, line_err SHALL pulse if byte phase odd (dangling byte dropped) or completed pixel count != H_ACTIVE.
REQ-016 FB during href high SHALL abort the line: no line_err, counters cleared, frame handling per REQ-009/010.
REQ-017 pix_data SHALL hold last value when pix_valid is low.
REQ-018 All pulse outputs SHALL be exactly one cycle wide; frame_* and line_err from same event SHALL be coincident.
REQ-019 Throughput: one pixel per two clk sustained; no back-pressure, no buffering beyond the pipeline.

Reset
REQ-020 rst_n low SHALL asynchronously force state SKIP (WAIT_FB if FRAME_SKIP = 0), skip count 0, byte phase 0, pix_data 0, pix_x 0, pix_y 0, all pulse and valid outputs 0.
REQ-021 Reset deasserted mid-frame SHALL produce no pix_valid until a full SKIP/WAIT_FB sequence completes.

Verification
REQ-022 FRAME_SKIP=2, H=4, V=2: three frames of bytes 0x12,0x34,... -> no pix_valid for frames 1-2; frame 3 yields pix_data 0x1234,0x5678,... with pix_x 0..3, pix_y 0..1, frame_done no frame_err.
REQ-023 Line with 9 bytes (H=4) -> 4 pixels valid, last byte dropped, line_err pulse at LE.
REQ-024 Line with 12 bytes (H=4) -> pixels 0..3 valid, pixels 4-5 suppressed, line_err pulse.
REQ-025 Frame with 1 line (V=2) -> frame_done and frame_err coincident at next FB.
REQ-026 FB asserted mid-line -> no line_err, frame_start pulse, pix_x/pix_y restart at 0 next line.
REQ-027 rst_n low during CAPTURE mid-line -> outputs 0 immediately; after release, no pix_valid until FRAME_SKIP FBs plus one further FB.
